// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and defaults for the instruction fetch sequencer
//
// Holds the fetch FSM state encoding and the default address width, data width
// and reset PC. Imported by fetch_pc_reg and fetch_sequencer.
package fetch_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  localparam int unsigned RESET_ADDR_DEF = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_STALL = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - program counter register with load and increment controls
//
// Ports:
//   clk, reset  : rising-edge clock, asynchronous active-high reset (pc = RESET_ADDR)
//   load        : take load_addr (redirect); has priority over inc
//   load_addr   : redirect target
//   inc         : advance pc by one word, wrapping modulo 2^ADDR_W
//   pc          : current program counter
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int unsigned RESET_ADDR = RESET_ADDR_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= ADDR_W'(RESET_ADDR);
    end else if (load) begin
      pc <= load_addr;
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch control: PC, imem request/ack, IF output, redirects
//
// Ports:
//   clk, reset              : rising-edge clock, asynchronous active-high reset
//   CE                      : fetch enable; 0 stops issuing new requests
//   stall_i                 : downstream cannot accept, hold IF output
//   redirect_valid/_addr    : taken branch/jump and its target PC
//   imem_req/imem_addr      : read request and address of the outstanding request
//   imem_ack/imem_data      : read data valid (same cycle or later) and instruction word
//   if_valid/if_pc/if_instr : IF/ID boundary output
//   fetch_cnt/flush_cnt     : saturating perf counters, only with FETCH_PERF_CNT_EN defined
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int unsigned RESET_ADDR = RESET_ADDR_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CE,
  input  logic              stall_i,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_data,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0]       fetch_cnt,
  output logic [15:0]       flush_cnt,
`endif
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_instr
);

  fetch_state_t      state, next_state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] drain_addr;
  logic              accept;
  logic              out_blocked;

  assign out_blocked = if_valid && stall_i;

  fetch_pc_reg #(
    .ADDR_W    (ADDR_W),
    .RESET_ADDR(RESET_ADDR)
  ) u_pc (
    .clk      (clk),
    .reset    (reset),
    .load     (redirect_valid),
    .load_addr(redirect_addr),
    .inc      (accept),
    .pc       (pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (redirect_valid) begin
      // A request the memory has seen but not answered must be drained first.
      next_state = (imem_req && !imem_ack) ? ST_DRAIN : ST_REQ;
    end else begin
      case (state)
        ST_IDLE:  if (CE) next_state = ST_REQ;
        ST_REQ: begin
          if (!imem_req) begin
            next_state = ST_STALL;
          end else if (imem_ack) begin
            next_state = CE ? ST_REQ : ST_IDLE;
          end
        end
        ST_STALL: if (!stall_i) next_state = CE ? ST_REQ : ST_IDLE;
        ST_DRAIN: if (imem_ack) next_state = ST_REQ;
        default:  next_state = ST_IDLE;
      endcase
    end
  end

  // While a request is outstanding if_valid is always 0 (it was issued with the
  // output free and no ack refilled it), so out_blocked can only suppress a
  // request that has not yet been issued; req/addr stay stable until the ack.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc;
    case (state)
      ST_REQ:   imem_req = !out_blocked;
      ST_DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = drain_addr;
      end
      default:  imem_req = 1'b0;
    endcase
  end

  assign accept = (state == ST_REQ) && imem_req && imem_ack && !redirect_valid;

  // Remember the wrong-path address; in DRAIN this re-captures the same value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drain_addr <= ADDR_W'(RESET_ADDR);
    end else if (redirect_valid && imem_req && !imem_ack) begin
      drain_addr <= imem_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_instr <= '0;
    end else if (redirect_valid) begin
      if_valid <= 1'b0;
    end else if (accept) begin
      if_valid <= 1'b1;
      if_pc    <= pc;
      if_instr <= imem_data;
    end else if (!stall_i) begin
      if_valid <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (accept && fetch_cnt != 16'hFFFF) fetch_cnt <= fetch_cnt + 16'd1;
      if (redirect_valid && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`else
  // Perf counters not built.
`endif

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Control block for the instruction fetch stage. It owns the program counter value, issues request/acknowledge reads to instruction memory, and presents fetched instructions to the IF/ID boundary with valid/stall flow control. It also handles branch/jump redirects, discarding wrong-path responses. It sits between the PC register, instruction memory and the IF/ID pipeline register.

Parameters:
ADDR_W, 5, PC/instruction-memory address width (word addressed)
DATA_W, 32, instruction width
RESET_ADDR, 0, PC value after reset

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
CE  in  1  fetch enable; 0 = stop issuing new requests
stall_i  in  1  downstream cannot accept; hold IF output
redirect_valid  in  1  branch/jump taken this cycle
redirect_addr  in  ADDR_W  target PC for redirect
imem_req  out  1  read request to instruction memory
imem_addr  out  ADDR_W  read address, equal to the PC of the outstanding request
imem_ack  in  1  read data valid; may arrive in the same cycle as the request or later
imem_data  in  DATA_W  instruction word
if_valid  out  1  if_instr/if_pc hold a valid instruction
if_pc  out  ADDR_W  PC of if_instr
if_instr  out  DATA_W  fetched instruction

Behaviour:
- Reset (async, active-high): pc=RESET_ADDR, state=IDLE, imem_req=0, imem_addr=RESET_ADDR, if_valid=0, if_pc=0, if_instr=0.
- States: IDLE, REQ, STALL, DRAIN.
- IDLE:
  - imem_req=0.
  - CE=1 -> REQ next cycle.
- REQ:
  - imem_req=1 and imem_addr=pc. Both are held stable until imem_ack=1.
  - Ack with no redirect and output free (if_valid=0 or stall_i=0): if_instr<=imem_data, if_pc<=pc, if_valid<=1, and pc<=pc+1 on the same edge.
  - After the ack: if CE=1, stay in REQ (back-to-back fetch, 1 instr/cycle when ack is same-cycle); otherwise go to IDLE.
- PC arithmetic: pc increments modulo 2^ADDR_W; 11111 wraps to 00000 with no flag.
- STALL:
  - Entered from REQ when if_valid=1 and stall_i=1 at the start of a new request (no request outstanding). imem_req=0.
  - Outputs are held.
  - When stall_i falls: if_valid<=0 unless reloaded, then return to REQ (or IDLE if CE=0).
- Output consumption: with stall_i=0 and no new ack, if_valid<=0 on the next edge.
- Redirect (highest priority):
  - pc<=redirect_addr and if_valid<=0 on the same edge.
  - No request outstanding, or imem_ack in the same cycle: any returned data is discarded; next state is REQ at redirect_addr.
  - Request outstanding without ack: go to DRAIN. imem_req stays high at the old address until ack, the data is discarded, then REQ at the new pc.
  - A second redirect during DRAIN overwrites pc; the last redirect wins.
- CE=0 mid-request: the outstanding request completes normally, then IDLE. No new request is issued.
- Simultaneous stall_i=1 and redirect_valid=1: the redirect wins and if_valid is cleared.
- An imem_ack while imem_req=0 is ignored.
- Latency: ack at edge N -> if_valid=1 after edge N. A redirect at edge N -> first request at redirect_addr in cycle N+1 (no drain) or in the cycle after the drain ack.

Optional Feature:
FETCH_PERF_CNT_EN:
- Defined: adds 16-bit output ports fetch_cnt and flush_cnt, both reset to 0.
  - fetch_cnt increments on every ack accepted into the IF output.
  - flush_cnt increments on every redirect.
  - Both counters saturate at 16'hFFFF.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package fetch_pkg: state encoding (IDLE, REQ, STALL, DRAIN), ADDR_W/DATA_W defaults, RESET_ADDR constant.
- One natural sub-module, fetch_pc_reg: async-reset PC register with load (redirect) and increment controls.
- The FSM and the IF output register stay in fetch_sequencer.

Test Plan:
- Reset, CE=1, same-cycle ack, imem_data=0x1000_0000+addr -> if_pc 0,1,2,… every cycle; if_instr matches; wrap 31->0.
- Ack delayed 3 cycles -> imem_req and imem_addr stable for 3 cycles; if_valid pulses once per ack.
- if_valid=1 with stall_i=1 for 4 cycles -> if_instr/if_pc held, imem_req=0; stall released -> next fetch at pc+1.
- redirect_valid with redirect_addr=5'd20 while request at 7 is outstanding -> DRAIN; ack data discarded (if_valid=0); next imem_addr=20.
- reset asserted mid-DRAIN -> all outputs return to reset values immediately; first request after reset goes to RESET_ADDR.
- With FETCH_PERF_CNT_EN defined: 10 fetches and 2 redirects -> fetch_cnt=10, flush_cnt=2.
